multicycle_ctrl_fsm: RTL

Main control unit of the multicycle CPU. It is a Moore FSM with one Mealy term, sitting directly upstream of the datapath: it consumes the decoded opcode/funct and the ALU flags, and produces every mux select and register write enable for the next cycle. It sequences fetch, decode, execute, memory and writeback, plus the reset and exception-entry sequences.

---
 rtl/multicycle_ctrl_fsm.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle CPU main control FSM (Moore with one Mealy branch term)
module multicycle_ctrl_fsm #(
    parameter int SP_INIT = 227,
    parameter int VEC_INV = 253,
    parameter int VEC_OVF = 254
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic [1:0] iord,
    output logic [1:0] error_sel,
    output logic       mem_write,
    output logic [1:0] store_size,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       a_write,
    output logic       b_write,
    output logic       aluout_write,
    output logic       epc_write,
    output logic       reg_write,
    output logic [2:0] reg_dst,
    output logic [3:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [2:0] pc_source,
    output logic       load_size,
    output logic [5:0] state_out
);

    typedef enum logic [5:0] {
        S_RESET      = 6'd0,
        S_FETCH_WAIT = 6'd1,
        S_FETCH      = 6'd2,
        S_DECODE     = 6'd3,
        S_R_EXEC     = 6'd4,
        S_R_WB       = 6'd5,
        S_ADDI_EXEC  = 6'd6,
        S_ADDI_WB    = 6'd7,
        S_ADDR       = 6'd8,
        S_LW_WAIT    = 6'd9,
        S_LW_MDR     = 6'd10,
        S_LW_WB      = 6'd11,
        S_SW_MEM     = 6'd12,
        S_BRANCH     = 6'd13,
        S_JUMP       = 6'd14,
        S_RTE        = 6'd15,
        S_EXC_SAVE   = 6'd16,
        S_EXC_WAIT   = 6'd17,
        S_EXC_MDR    = 6'd18,
        S_EXC_JUMP   = 6'd19
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_RTE   = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    localparam logic CAUSE_INV = 1'b0;
    localparam logic CAUSE_OVF = 1'b1;

    // The vector addresses and SP_INIT are consumed by the datapath constants;
    // two causes sharing one vector slot would make them indistinguishable.
    if ((VEC_INV == VEC_OVF) || (SP_INIT == VEC_INV)) begin : g_bad_config
    end

    state_t state;
    state_t next_state;
    logic   cause;
    logic   next_cause;

    // State register; the cause bit is captured whenever exception entry is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RESET;
            cause <= CAUSE_INV;
        end else begin
            state <= next_state;
            if (next_state == S_EXC_SAVE) begin
                cause <= next_cause;
            end
        end
    end

    // Next-state and per-state control outputs; everything defaults to 0.
    always_comb begin
        next_state   = S_RESET;
        next_cause   = CAUSE_INV;
        pc_write     = 1'b0;
        iord         = 2'd0;
        error_sel    = 2'd0;
        mem_write    = 1'b0;
        store_size   = 2'd0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        a_write      = 1'b0;
        b_write      = 1'b0;
        aluout_write = 1'b0;
        epc_write    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 3'd0;
        mem_to_reg   = 4'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu_ctrl     = 3'b000;
        pc_source    = 3'd0;
        load_size    = 1'b0;

        case (state)
            S_RESET: begin
                reg_dst    = 3'd2;
                mem_to_reg = 4'd2;
                reg_write  = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                iord       = 2'd0;
                next_state = S_FETCH;
            end
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b0;
                alu_src_b  = 2'd1;
                alu_ctrl   = ALU_ADD;
                pc_source  = 3'd0;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                a_write      = 1'b1;
                b_write      = 1'b1;
                alu_src_a    = 1'b0;
                alu_src_b    = 2'd3;
                alu_ctrl     = ALU_ADD;
                aluout_write = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
                            next_state = S_R_EXEC;
                        end else begin
                            next_state = S_EXC_SAVE;
                            next_cause = CAUSE_INV;
                        end
                    end
                    OP_ADDI:        next_state = S_ADDI_EXEC;
                    OP_LW, OP_SW:   next_state = S_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    OP_RTE:         next_state = S_RTE;
                    default: begin
                        next_state = S_EXC_SAVE;
                        next_cause = CAUSE_INV;
                    end
                endcase
            end
            S_R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'd0;
                aluout_write = 1'b1;
                case (funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
                // and cannot overflow, so the flag is ignored for it
                if (alu_overflow && (funct == FN_ADD || funct == FN_SUB)) begin
                    next_state = S_EXC_SAVE;
                    next_cause = CAUSE_OVF;
                end else begin
                    next_state = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_dst    = 3'd1;
                mem_to_reg = 4'd0;
                reg_write  = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            S_ADDI_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'd2;
                alu_ctrl     = ALU_ADD;
                aluout_write = 1'b1;
                if (alu_overflow) begin
                    next_state = S_EXC_SAVE;
                    next_cause = CAUSE_OVF;
                end else begin
                    next_state = S_ADDI_WB;
                end
            end
            S_ADDI_WB: begin
                reg_dst    = 3'd0;
                mem_to_reg = 4'd0;
                reg_write  = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            S_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'd2;
                alu_ctrl     = ALU_ADD;
                aluout_write = 1'b1;
                next_state   = (opcode == OP_SW) ? S_SW_MEM : S_LW_WAIT;
            end
            S_LW_WAIT: begin
                iord       = 2'd1;
                next_state = S_LW_MDR;
            end
            S_LW_MDR: begin
                mdr_write  = 1'b1;
                next_state = S_LW_WB;
            end
            S_LW_WB: begin
                reg_dst    = 3'd0;
                mem_to_reg = 4'd1;
                reg_write  = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            S_SW_MEM: begin
                iord       = 2'd1;
                mem_write  = 1'b1;
                store_size = 2'd0;
                next_state = S_FETCH_WAIT;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd0;
                alu_ctrl   = ALU_SUB;
                pc_source  = 3'd1;
                // The only Mealy output: taken-ness comes from this cycle's compare.
                pc_write   = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
                next_state = S_FETCH_WAIT;
            end
            S_JUMP: begin
                pc_source  = 3'd2;
                pc_write   = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            S_RTE: begin
                pc_source  = 3'd4;
                pc_write   = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            S_EXC_SAVE: begin
                // PC already advanced in FETCH, so EPC gets PC-4.
                alu_src_a  = 1'b0;
                alu_src_b  = 2'd1;
                alu_ctrl   = ALU_SUB;
                epc_write  = 1'b1;
                next_state = S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                iord       = 2'd2;
                error_sel  = {1'b0, cause};
                next_state = S_EXC_MDR;
            end
            S_EXC_MDR: begin
                mdr_write  = 1'b1;
                next_state = S_EXC_JUMP;
            end
            S_EXC_JUMP: begin
                pc_source  = 3'd3;
                pc_write   = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    assign state_out = state;

endmodule
